// File: rtl/store_align_buffer_pkg.sv
// Shared definitions for the store alignment buffer: datapath width and store opcodes.
package store_align_buffer_pkg;

  localparam int DWIDTH       = 32;
  localparam int OPCODE_WIDTH = 2;

  localparam logic [OPCODE_WIDTH-1:0] STORE_NONE = 2'b00;
  localparam logic [OPCODE_WIDTH-1:0] STORE_WORD = 2'b01;
  localparam logic [OPCODE_WIDTH-1:0] STORE_HALF = 2'b10;
  localparam logic [OPCODE_WIDTH-1:0] STORE_BYTE = 2'b11;

endpackage

// File: rtl/store_lane_steer.sv
// Combinational byte-lane steering: aligns LSB-justified store data and builds the byte mask.
module store_lane_steer #(
  parameter int DWIDTH = store_align_buffer_pkg::DWIDTH
) (
  input  logic [store_align_buffer_pkg::OPCODE_WIDTH-1:0] opcode,
  input  logic [1:0]                                      offset,
  input  logic [DWIDTH-1:0]                               data,
  output logic [DWIDTH-1:0]                               lane_data,
  output logic [DWIDTH/8-1:0]                             lane_mask,
  output logic                                            is_store,
  output logic                                            legal
);
  import store_align_buffer_pkg::*;

  localparam int LANES = DWIDTH / 8;

  logic [DWIDTH-1:0] field;
  logic [LANES-1:0]  base_mask;

  always_comb begin
    field     = '0;
    base_mask = '0;
    is_store  = 1'b1;
    legal     = 1'b0;
    case (opcode)
      STORE_WORD: begin
        field     = data;
        base_mask = LANES'(4'b1111);
        legal     = (offset == 2'b00);
      end
      STORE_HALF: begin
        field     = DWIDTH'(data[15:0]);
        base_mask = LANES'(4'b0011);
        legal     = ~offset[0];
      end
      STORE_BYTE: begin
        field     = DWIDTH'(data[7:0]);
        base_mask = LANES'(4'b0001);
        legal     = 1'b1;
      end
      default: is_store = 1'b0;
    endcase
    lane_mask = base_mask << offset;
    lane_data = field << {offset, 3'b000};
  end

endmodule

// File: rtl/store_align_buffer.sv
// Store alignment FIFO: steers accepted stores into byte lanes and queues them for memory.
module store_align_buffer #(
  parameter int DWIDTH = store_align_buffer_pkg::DWIDTH,
  parameter int AWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  logic                                            sab_i_clk,
  input  logic                                            sab_i_rst,
  input  logic                                            sab_i_valid,
  output logic                                            sab_o_ready,
  input  logic [store_align_buffer_pkg::OPCODE_WIDTH-1:0] sab_i_opcode,
  input  logic [AWIDTH-1:0]                               sab_i_addr,
  input  logic [DWIDTH-1:0]                               sab_i_data,
  output logic                                            sab_o_misalign,
  output logic                                            sab_o_mem_valid,
  input  logic                                            sab_i_mem_ready,
  output logic [AWIDTH-1:0]                               sab_o_mem_addr,
  output logic [DWIDTH-1:0]                               sab_o_mem_data,
  output logic [DWIDTH/8-1:0]                             sab_o_mem_mask,
  output logic [$clog2(DEPTH):0]                          sab_o_count
);
  localparam int LANES = DWIDTH / 8;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;

  logic [AWIDTH-1:0] addr_q [DEPTH];
  logic [DWIDTH-1:0] data_q [DEPTH];
  logic [LANES-1:0]  mask_q [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          misalign_q;

  logic [DWIDTH-1:0] st_data;
  logic [LANES-1:0]  st_mask;
  logic              st_is_store;
  logic              st_legal;
  logic              accept;
  logic              enq;
  logic              deq;

  store_lane_steer #(.DWIDTH(DWIDTH)) u_steer (
    .opcode    (sab_i_opcode),
    .offset    (sab_i_addr[1:0]),
    .data      (sab_i_data),
    .lane_data (st_data),
    .lane_mask (st_mask),
    .is_store  (st_is_store),
    .legal     (st_legal)
  );

  // Ready depends only on occupancy, so a full buffer refuses even when a dequeue is in flight.
  assign sab_o_ready     = (count != CW'(DEPTH));
  assign sab_o_mem_valid = (count != '0);
  assign accept          = sab_i_valid & sab_o_ready;
  assign enq             = accept & st_is_store & st_legal;
  assign deq             = sab_o_mem_valid & sab_i_mem_ready;

  assign sab_o_mem_addr = sab_o_mem_valid ? addr_q[rd_ptr] : '0;
  assign sab_o_mem_data = sab_o_mem_valid ? data_q[rd_ptr] : '0;
  assign sab_o_mem_mask = sab_o_mem_valid ? mask_q[rd_ptr] : '0;
  assign sab_o_count    = count;
  assign sab_o_misalign = misalign_q;

  always_ff @(posedge sab_i_clk) begin
    if (!sab_i_rst && enq) begin
      addr_q[wr_ptr] <= {sab_i_addr[AWIDTH-1:2], 2'b00};
      data_q[wr_ptr] <= st_data;
      mask_q[wr_ptr] <= st_mask;
    end
  end

  always_ff @(posedge sab_i_clk) begin
    if (sab_i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      misalign_q <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      misalign_q <= accept & st_is_store & ~st_legal;
    end
  end

endmodule

// File: tb/tb_store_align_buffer.sv
// Directed bench for store_align_buffer with hand-computed expected values.
module tb_store_align_buffer;
  import store_align_buffer_pkg::*;

  logic        clk;
  logic        rst;
  logic        valid;
  logic        ready;
  logic [1:0]  opcode;
  logic [31:0] addr;
  logic [31:0] data;
  logic        misalign;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_mask;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  store_align_buffer #(.DWIDTH(32), .AWIDTH(32), .DEPTH(4)) dut (
    .sab_i_clk       (clk),
    .sab_i_rst       (rst),
    .sab_i_valid     (valid),
    .sab_o_ready     (ready),
    .sab_i_opcode    (opcode),
    .sab_i_addr      (addr),
    .sab_i_data      (data),
    .sab_o_misalign  (misalign),
    .sab_o_mem_valid (mem_valid),
    .sab_i_mem_ready (mem_ready),
    .sab_o_mem_addr  (mem_addr),
    .sab_o_mem_data  (mem_data),
    .sab_o_mem_mask  (mem_mask),
    .sab_o_count     (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    valid  = 1'b1;
    opcode = op;
    addr   = a;
    data   = d;
  endtask

  task automatic idle();
    valid  = 1'b0;
    opcode = STORE_NONE;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    mem_ready = 1'b0;
    repeat (2) tick();
    checks++; if ({count, mem_valid, misalign, ready} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin errors++; $display("FAIL reset_ctrl got %b exp %b", {count, mem_valid, misalign, ready}, {3'd0, 1'b0, 1'b0, 1'b1}); end
    checks++; if ({mem_addr, mem_data, mem_mask} !== 68'd0) begin errors++; $display("FAIL reset_mem got %h/%h/%b exp 0/0/0", mem_addr, mem_data, mem_mask); end
    rst = 1'b0;
    tick();
    checks++; if ({count, ready} !== {3'd0, 1'b1}) begin errors++; $display("FAIL reset_release got %b exp %b", {count, ready}, {3'd0, 1'b1}); end
  endtask

  task automatic test_word();
    mem_ready = 1'b1;
    put(STORE_WORD, 32'h104, 32'hDEADBEEF);
    tick();
    idle();
    checks++; if ({mem_valid, count} !== {1'b1, 3'd1}) begin errors++; $display("FAIL word_valid got %b exp %b", {mem_valid, count}, {1'b1, 3'd1}); end
    checks++; if ({mem_addr, mem_data, mem_mask} !== {32'h104, 32'hDEADBEEF, 4'b1111}) begin errors++; $display("FAIL word_head got %h/%h/%b exp 104/deadbeef/1111", mem_addr, mem_data, mem_mask); end
    tick();
    checks++; if ({mem_valid, count, mem_data, mem_mask} !== {1'b0, 3'd0, 32'h0, 4'b0}) begin errors++; $display("FAIL word_drain got %b/%0d/%h/%b exp 0/0/0/0", mem_valid, count, mem_data, mem_mask); end
    mem_ready = 1'b0;
  endtask

  task automatic test_byte_half();
    mem_ready = 1'b0;
    put(STORE_BYTE, 32'h203, 32'h000000A5);
    tick();
    checks++; if ({mem_addr, mem_data, mem_mask} !== {32'h200, 32'hA5000000, 4'b1000}) begin errors++; $display("FAIL sb_head got %h/%h/%b exp 200/a5000000/1000", mem_addr, mem_data, mem_mask); end
    put(STORE_HALF, 32'h202, 32'h00001234);
    tick();
    put(STORE_BYTE, 32'h101, 32'hFFFFFF5A);
    tick();
    idle();
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL bh_count got %0d exp 3", count); end
    checks++; if ({mem_addr, mem_data, mem_mask} !== {32'h200, 32'hA5000000, 4'b1000}) begin errors++; $display("FAIL bh_hold got %h/%h/%b exp 200/a5000000/1000", mem_addr, mem_data, mem_mask); end
    mem_ready = 1'b1;
    tick();
    checks++; if ({count, mem_addr, mem_data, mem_mask} !== {3'd2, 32'h200, 32'h12340000, 4'b1100}) begin errors++; $display("FAIL sh_head got %0d/%h/%h/%b exp 2/200/12340000/1100", count, mem_addr, mem_data, mem_mask); end
    tick();
    checks++; if ({count, mem_addr, mem_data, mem_mask} !== {3'd1, 32'h100, 32'h00005A00, 4'b0010}) begin errors++; $display("FAIL sb1_head got %0d/%h/%h/%b exp 1/100/00005a00/0010", count, mem_addr, mem_data, mem_mask); end
    tick();
    checks++; if ({mem_valid, count} !== {1'b0, 3'd0}) begin errors++; $display("FAIL bh_empty got %b exp %b", {mem_valid, count}, {1'b0, 3'd0}); end
    mem_ready = 1'b0;
  endtask

  task automatic test_misalign();
    mem_ready = 1'b0;
    put(STORE_WORD, 32'h102, 32'h11111111);
    tick();
    idle();
    checks++; if ({misalign, count} !== {1'b1, 3'd0}) begin errors++; $display("FAIL sw_misalign got %b exp %b", {misalign, count}, {1'b1, 3'd0}); end
    tick();
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL sw_pulse got %b exp 0", misalign); end
    put(STORE_HALF, 32'h101, 32'h2222);
    tick();
    idle();
    checks++; if ({misalign, count} !== {1'b1, 3'd0}) begin errors++; $display("FAIL sh_misalign got %b exp %b", {misalign, count}, {1'b1, 3'd0}); end
    tick();
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL sh_pulse got %b exp 0", misalign); end
    put(STORE_NONE, 32'h101, 32'h3333);
    tick();
    idle();
    checks++; if ({misalign, count, mem_valid, ready} !== {1'b0, 3'd0, 1'b0, 1'b1}) begin errors++; $display("FAIL nonstore got %b exp %b", {misalign, count, mem_valid, ready}, {1'b0, 3'd0, 1'b0, 1'b1}); end
  endtask

  task automatic test_full();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put(STORE_WORD, 32'h1000 + 4 * i, 32'hA0000000 + i);
      tick();
    end
    checks++; if ({ready, count} !== {1'b0, 3'd4}) begin errors++; $display("FAIL full_state got %b exp %b", {ready, count}, {1'b0, 3'd4}); end
    put(STORE_WORD, 32'h1010, 32'hA0000004);
    tick();
    checks++; if ({ready, count, mem_addr} !== {1'b0, 3'd4, 32'h1000}) begin errors++; $display("FAIL full_hold got %b/%0d/%h exp 0/4/1000", ready, count, mem_addr); end
    mem_ready = 1'b1;
    tick();
    checks++; if ({ready, count, mem_addr, mem_data} !== {1'b1, 3'd3, 32'h1004, 32'hA0000001}) begin errors++; $display("FAIL full_deq got %b/%0d/%h/%h exp 1/3/1004/a0000001", ready, count, mem_addr, mem_data); end
    tick();
    idle();
    checks++; if ({count, mem_addr, mem_data} !== {3'd3, 32'h1008, 32'hA0000002}) begin errors++; $display("FAIL full_5th got %0d/%h/%h exp 3/1008/a0000002", count, mem_addr, mem_data); end
    tick();
    checks++; if ({count, mem_addr, mem_data} !== {3'd2, 32'h100C, 32'hA0000003}) begin errors++; $display("FAIL drain_3 got %0d/%h/%h exp 2/100c/a0000003", count, mem_addr, mem_data); end
    tick();
    checks++; if ({count, mem_addr, mem_data} !== {3'd1, 32'h1010, 32'hA0000004}) begin errors++; $display("FAIL drain_4 got %0d/%h/%h exp 1/1010/a0000004", count, mem_addr, mem_data); end
    tick();
    checks++; if ({mem_valid, count} !== {1'b0, 3'd0}) begin errors++; $display("FAIL full_empty got %b exp %b", {mem_valid, count}, {1'b0, 3'd0}); end
    mem_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    mem_ready = 1'b0;
    put(STORE_WORD, 32'h2000, 32'h2000);
    tick();
    put(STORE_WORD, 32'h2004, 32'h2004);
    tick();
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_prefill got %0d exp 2", count); end
    mem_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      put(STORE_WORD, 32'h2008 + 4 * k, 32'h2008 + 4 * k);
      tick();
      checks++; if ({count, mem_addr, mem_data} !== {3'd2, 32'h2000 + 32'(4 * (k + 1)), 32'h2000 + 32'(4 * (k + 1))}) begin errors++; $display("FAIL b2b_step%0d got %0d/%h/%h exp 2/%h", k, count, mem_addr, mem_data, 32'h2000 + 4 * (k + 1)); end
    end
    idle();
    tick();
    checks++; if ({count, mem_addr} !== {3'd1, 32'h2024}) begin errors++; $display("FAIL b2b_tail got %0d/%h exp 1/2024", count, mem_addr); end
    tick();
    checks++; if ({mem_valid, count} !== {1'b0, 3'd0}) begin errors++; $display("FAIL b2b_empty got %b exp %b", {mem_valid, count}, {1'b0, 3'd0}); end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(STORE_BYTE, 32'h300 + i, 32'h11 * (i + 1));
      tick();
    end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL rstmid_fill got %0d exp 3", count); end
    put(STORE_WORD, 32'h400, 32'h44444444);
    mem_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    mem_ready = 1'b0;
    checks++; if ({count, mem_valid, ready, misalign} !== {3'd0, 1'b0, 1'b1, 1'b0}) begin errors++; $display("FAIL rstmid_ctrl got %b exp %b", {count, mem_valid, ready, misalign}, {3'd0, 1'b0, 1'b1, 1'b0}); end
    checks++; if ({mem_addr, mem_data, mem_mask} !== 68'd0) begin errors++; $display("FAIL rstmid_mem got %h/%h/%b exp 0/0/0", mem_addr, mem_data, mem_mask); end
    put(STORE_WORD, 32'h3000, 32'h77777777);
    tick();
    idle();
    checks++; if ({count, mem_addr, mem_data, mem_mask} !== {3'd1, 32'h3000, 32'h77777777, 4'b1111}) begin errors++; $display("FAIL rstmid_new got %0d/%h/%h/%b exp 1/3000/77777777/1111", count, mem_addr, mem_data, mem_mask); end
    mem_ready = 1'b1;
    tick();
    checks++; if ({mem_valid, count} !== {1'b0, 3'd0}) begin errors++; $display("FAIL rstmid_empty got %b exp %b", {mem_valid, count}, {1'b0, 3'd0}); end
    mem_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    valid     = 1'b0;
    opcode    = STORE_NONE;
    addr      = '0;
    data      = '0;
    mem_ready = 1'b0;
    test_reset();
    test_word();
    test_byte_half();
    test_misalign();
    test_full();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_align_buffer.md
STORE_ALIGN_BUFFER -- requirements
Module: store_align_buffer

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, datapath width; byte lanes NB = DWIDTH/8; only 32 supported this generation.
REQ-002 SHALL have parameter AWIDTH, default 32, byte address width.
REQ-003 SHALL have parameter DEPTH, default 4, buffer entries; power of two, >= 2.
REQ-004 sab_i_clk  in  1  single clock; all state updates on rising edge.
REQ-005 sab_i_rst  in  1  reset, synchronous, active-high.
REQ-006 sab_i_valid  in  1  store request present.
REQ-007 sab_o_ready  out  1  buffer can accept a request.
REQ-008 sab_i_opcode  in  OPCODE_WIDTH  store type: STORE_WORD / STORE_HALF / STORE_BYTE.
REQ-009 sab_i_addr  in  AWIDTH  byte address of the store.
REQ-010 sab_i_data  in  DWIDTH  unaligned store data, LSB-justified.
REQ-011 sab_o_misalign  out  1  one-cycle pulse: rejected misaligned store.
REQ-012 sab_o_mem_valid  out  1  head entry presented to memory.
REQ-013 sab_i_mem_ready  in  1  memory accepts head entry.
REQ-014 sab_o_mem_addr  out  AWIDTH  word address, low 2 bits zero.
REQ-015 sab_o_mem_data  out  DWIDTH  lane-steered data.
REQ-016 sab_o_mem_mask  out  NB  byte-enable mask.
REQ-017 sab_o_count  out  clog2(DEPTH)+1  occupied entries.

Function
REQ-018 Accept SHALL occur on an edge where sab_i_valid and sab_o_ready are both high.
REQ-019 sab_o_ready SHALL equal (count != DEPTH), independent of sab_i_mem_ready; no enqueue while full, even with a simultaneous dequeue.
REQ-020 Offset off = sab_i_addr[1:0]; alignment legal iff WORD: off==0; HALF: off[0]==0; BYTE: any.
REQ-021 Legal accept SHALL enqueue mask = (WORD 4'b1111, HALF 4'b0011, BYTE 4'b0001) << off, data = zero-extended field << 8*off, addr = {sab_i_addr[AWIDTH-1:2], 2'b00}.
REQ-022 Illegal alignment on accept SHALL NOT enqueue and SHALL raise sab_o_misalign for exactly the following cycle.
REQ-023 Non-store opcode on accept SHALL be consumed, not enqueued, no misalign pulse.
REQ-024 sab_o_mem_valid SHALL equal (count != 0); mem addr/data/mask SHALL reflect the oldest entry (FIFO order).
REQ-025 Dequeue SHALL occur on an edge where sab_o_mem_valid and sab_i_mem_ready are both high.
REQ-026 While sab_o_mem_valid high and sab_i_mem_ready low, all mem outputs SHALL hold stable.
REQ-027 Latency: an entry enqueued into an empty buffer at edge N SHALL be presented from edge N on (visible cycle N+1); no same-cycle bypass.
REQ-028 Simultaneous enqueue and dequeue SHALL leave count unchanged; read and write pointers wrap modulo DEPTH.
REQ-029 When empty, mem data/mask SHALL drive zero.

Reset
REQ-030 On sab_i_rst at an edge: count=0, pointers=0, sab_o_mem_valid=0, sab_o_misalign=0, sab_o_ready=1, mem addr/data/mask=0.
REQ-031 Reset mid-operation SHALL discard all entries; an accept or dequeue coincident with reset SHALL be ignored.

Structure
REQ-032 STORE_* opcode codes, OPCODE_WIDTH and DWIDTH SHALL come from the shared header; no local redefinition.
REQ-033 Lane steering/mask generation SHALL be one combinational sub-module, store_lane_steer; the FIFO and control SHALL live in store_align_buffer.

Verification
REQ-034 SW addr 0x104 data 0xDEADBEEF, mem_ready=1 -> next cycle mem addr 0x104, data 0xDEADBEEF, mask 1111, then empty.
REQ-035 SB addr 0x203 data 0x000000A5 -> mem addr 0x200, data 0xA5000000, mask 1000; SH addr 0x202 data 0x1234 -> data 0x12340000, mask 1100.
REQ-036 SW addr 0x102 and SH addr 0x101 -> no enqueue, count unchanged, misalign pulses one cycle each.
REQ-037 mem_ready=0, issue 5 SW with DEPTH=4 -> ready low after 4th, count=4, 5th held; release mem_ready -> 4 stores drain in order, 5th accepted after first dequeue.
REQ-038 count=2, simultaneous accept and dequeue for 8 cycles -> count stays 2, pointers wrap, order preserved.
REQ-039 count=3, assert sab_i_rst one cycle -> next cycle count=0, mem_valid=0, ready=1; prior entries never appear.
